// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin bus arbiter with a two-slave address decoder.
// Requests are latched per master; each granted transfer walks IDLE -> ADDR -> RESP.
module bus_arbiter_2m #(
    parameter logic [7:0] DMAC_BASE = 8'h00,
    parameter logic [7:0] MEM_BASE  = 8'h01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req_i,
    input  logic        m1_req_i,
    input  logic        m0_wr_i,
    input  logic        m1_wr_i,
    input  logic [31:0] m0_address_i,
    input  logic [31:0] m1_address_i,
    input  logic [31:0] m0_dout_i,
    input  logic [31:0] m1_dout_i,
    output logic        m0_grant_o,
    output logic        m1_grant_o,
    output logic [31:0] m0_din_o,
    output logic [31:0] m1_din_o,
    output logic        s0_cs_o,
    output logic        s1_cs_o,
    output logic        s_wr_o,
    output logic [15:0] s_address_o,
    output logic [31:0] s_dout_o,
    input  logic [31:0] s0_din_i,
    input  logic [31:0] s1_din_i,
    output logic        busy_o,
    output logic [1:0]  owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic        last_q, last_d;
    logic        req_wr0_q, req_wr0_d, req_wr1_q, req_wr1_d;
    logic [15:0] req_addr0_q, req_addr0_d, req_addr1_q, req_addr1_d;
    logic [31:0] req_dout0_q, req_dout0_d, req_dout1_q, req_dout1_d;
    logic        wr_q, wr_d;
    logic [15:0] s_address_q, s_address_d;
    logic [31:0] s_dout_q, s_dout_d;
    logic        s0_cs_q, s0_cs_d, s1_cs_q, s1_cs_d;
    logic        s_wr_q, s_wr_d;
    logic [1:0]  owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        grant0_q, grant0_d, grant1_q, grant1_d;
    logic [31:0] din0_q, din0_d, din1_q, din1_d;

    logic        win1_s;
    logic [15:0] win_addr_s;
    logic [1:0]  win_cs_s;
    logic [31:0] rdata_s;
    logic        unused_addr_hi_s;

    function automatic logic [1:0] decode_cs(input logic [15:0] addr);
        logic [1:0] cs;
        cs = 2'b00;
        if (addr[15:8] == DMAC_BASE) begin
            cs = 2'b01;
        end else if (addr[15:8] == MEM_BASE) begin
            cs = 2'b10;
        end else begin
            cs = 2'b00;
        end
        return cs;
    endfunction

    // Unmapped transfers have no cs, so they read back zero.
    function automatic logic [31:0] read_mux(input logic cs0, input logic cs1,
                                             input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] r;
        r = 32'h0000_0000;
        if (cs0) begin
            r = d0;
        end else if (cs1) begin
            r = d1;
        end else begin
            r = 32'h0000_0000;
        end
        return r;
    endfunction

    assign unused_addr_hi_s = ^{m0_address_i[31:16], m1_address_i[31:16]};

    // Next-state: request latches, arbitration and the transfer FSM.
    always_comb begin
        state_d     = state_q;
        pend0_d     = pend0_q;
        pend1_d     = pend1_q;
        last_d      = last_q;
        req_wr0_d   = req_wr0_q;
        req_wr1_d   = req_wr1_q;
        req_addr0_d = req_addr0_q;
        req_addr1_d = req_addr1_q;
        req_dout0_d = req_dout0_q;
        req_dout1_d = req_dout1_q;
        wr_d        = wr_q;
        s_address_d = s_address_q;
        s_dout_d    = s_dout_q;
        s0_cs_d     = s0_cs_q;
        s1_cs_d     = s1_cs_q;
        s_wr_d      = s_wr_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        grant0_d    = 1'b0;
        grant1_d    = 1'b0;
        din0_d      = din0_q;
        din1_d      = din1_q;

        // On a tie the master that did not go last wins.
        win1_s     = pend1_q & ~(pend0_q & last_q);
        win_addr_s = win1_s ? req_addr1_q : req_addr0_q;
        win_cs_s   = decode_cs(win_addr_s);
        rdata_s    = read_mux(s0_cs_q, s1_cs_q, s0_din_i, s1_din_i);

        if (m0_req_i && !pend0_q) begin
            pend0_d     = 1'b1;
            req_wr0_d   = m0_wr_i;
            req_addr0_d = m0_address_i[15:0];
            req_dout0_d = m0_dout_i;
        end else begin
            pend0_d = pend0_q;
        end

        if (m1_req_i && !pend1_q) begin
            pend1_d     = 1'b1;
            req_wr1_d   = m1_wr_i;
            req_addr1_d = m1_address_i[15:0];
            req_dout1_d = m1_dout_i;
        end else begin
            pend1_d = pend1_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend0_q || pend1_q) begin
                    wr_d        = win1_s ? req_wr1_q : req_wr0_q;
                    s_wr_d      = win1_s ? req_wr1_q : req_wr0_q;
                    s_address_d = win_addr_s;
                    s_dout_d    = win1_s ? req_dout1_q : req_dout0_q;
                    s0_cs_d     = win_cs_s[0];
                    s1_cs_d     = win_cs_s[1];
                    owner_d     = win1_s ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    state_d     = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                s_wr_d  = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!wr_q && owner_q[1]) begin
                    din1_d = rdata_s;
                end else if (!wr_q) begin
                    din0_d = rdata_s;
                end else begin
                    din0_d = din0_q;
                end
                if (owner_q[1]) begin
                    grant1_d = 1'b1;
                    pend1_d  = 1'b0;
                end else begin
                    grant0_d = 1'b1;
                    pend0_d  = 1'b0;
                end
                last_d  = owner_q[1];
                s0_cs_d = 1'b0;
                s1_cs_d = 1'b0;
                s_wr_d  = 1'b0;
                owner_d = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                s0_cs_d = 1'b0;
                s1_cs_d = 1'b0;
                s_wr_d  = 1'b0;
                owner_d = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pend0_q     <= 1'b0;
            pend1_q     <= 1'b0;
            last_q      <= 1'b1;
            req_wr0_q   <= 1'b0;
            req_wr1_q   <= 1'b0;
            req_addr0_q <= 16'h0000;
            req_addr1_q <= 16'h0000;
            req_dout0_q <= 32'h0000_0000;
            req_dout1_q <= 32'h0000_0000;
            wr_q        <= 1'b0;
            s_address_q <= 16'h0000;
            s_dout_q    <= 32'h0000_0000;
            s0_cs_q     <= 1'b0;
            s1_cs_q     <= 1'b0;
            s_wr_q      <= 1'b0;
            owner_q     <= 2'b00;
            busy_q      <= 1'b0;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            din0_q      <= 32'h0000_0000;
            din1_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pend0_q     <= pend0_d;
            pend1_q     <= pend1_d;
            last_q      <= last_d;
            req_wr0_q   <= req_wr0_d;
            req_wr1_q   <= req_wr1_d;
            req_addr0_q <= req_addr0_d;
            req_addr1_q <= req_addr1_d;
            req_dout0_q <= req_dout0_d;
            req_dout1_q <= req_dout1_d;
            wr_q        <= wr_d;
            s_address_q <= s_address_d;
            s_dout_q    <= s_dout_d;
            s0_cs_q     <= s0_cs_d;
            s1_cs_q     <= s1_cs_d;
            s_wr_q      <= s_wr_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            grant0_q    <= grant0_d;
            grant1_q    <= grant1_d;
            din0_q      <= din0_d;
            din1_q      <= din1_d;
        end
    end

    assign m0_grant_o  = grant0_q;
    assign m1_grant_o  = grant1_q;
    assign m0_din_o    = din0_q;
    assign m1_din_o    = din1_q;
    assign s0_cs_o     = s0_cs_q;
    assign s1_cs_o     = s1_cs_q;
    assign s_wr_o      = s_wr_q;
    assign s_address_o = s_address_q;
    assign s_dout_o    = s_dout_q;
    assign busy_o      = busy_q;
    assign owner_o     = owner_q;

endmodule
